// File: rtl/enh_frame_ctrl_if.sv
// Host command channel for enh_frame_ctrl: valid/ready handshake carrying
// the enhancement operation, its operand and the number of frames to run.
interface enh_frame_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_value;
  logic [7:0] cmd_frames;

  modport master (output cmd_valid, cmd_op, cmd_value, cmd_frames, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_value, cmd_frames, output cmd_ready);
endinterface

// File: rtl/enh_frame_ctrl.sv
// Frame-level sequencer for the image enhancement datapath.
// Optional HSYNC watchdog in RUN is compiled in with ENH_FRAME_TIMEOUT_EN.
module enh_frame_ctrl #(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  enh_frame_ctrl_if.slave              cmd,
  input  logic                         abort,
  output logic                         rd_start,
  input  logic                         HSYNC,
  input  logic                         ctrl_done,
  output logic [1:0]                   op_mode,
  output logic [7:0]                   op_value,
  output logic [$clog2(WIDTH/2)-1:0]   col,
  output logic [$clog2(HEIGHT)-1:0]    row,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   frames_done,
  output logic                         err
);

  localparam int PAIRS = WIDTH * HEIGHT / 2;
  localparam int PCW   = $clog2(PAIRS + 1);
  localparam int CW    = $clog2(WIDTH / 2);
  localparam int RW    = $clog2(HEIGHT);

  if ((WIDTH % 2) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("enh_frame_ctrl: WIDTH must be even and TIMEOUT_CYC positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_ERR
  } state_t;

  state_t         state, state_nx;
  logic [PCW-1:0] pix_cnt, pix_inc;
  logic [1:0]     op_cap;
  logic [7:0]     val_cap;
  logic [7:0]     frames_cap;
  logic [7:0]     remaining;
  logic           frame_done_q;
  logic           overflow, frame_good, frame_bad, last_frame, good_commit, wd_expire;

`ifdef ENH_FRAME_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd;
`endif

  always_comb begin
    state_nx    = state;
    pix_inc     = pix_cnt + {{(PCW-1){1'b0}}, HSYNC};
    // The HSYNC of this cycle is counted before ctrl_done is judged.
    overflow    = HSYNC && (pix_cnt == PCW'(PAIRS));
    frame_good  = ctrl_done && !overflow && (pix_inc == PCW'(PAIRS));
    frame_bad   = ctrl_done && !overflow && (pix_inc != PCW'(PAIRS));
    last_frame  = (remaining == 8'd1) && (frames_cap != '0);
    good_commit = (state == S_RUN) && frame_good && !abort;
`ifdef ENH_FRAME_TIMEOUT_EN
    wd_expire   = !HSYNC && (wd == WDW'(TIMEOUT_CYC - 1));
`else
    wd_expire   = 1'b0;
`endif

    case (state)
      S_IDLE:  if (cmd.cmd_valid) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_START;
      S_START: state_nx = S_RUN;
      S_RUN: begin
        if (overflow || frame_bad || wd_expire) state_nx = S_ERR;
        else if (frame_good)                    state_nx = last_frame ? S_IDLE : S_START;
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase

    if (abort && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= S_IDLE;
      pix_cnt      <= '0;
      op_cap       <= '0;
      val_cap      <= '0;
      frames_cap   <= '0;
      remaining    <= '0;
      op_mode      <= '0;
      op_value     <= '0;
      col          <= '0;
      row          <= '0;
      frames_done  <= '0;
      frame_done_q <= 1'b0;
`ifdef ENH_FRAME_TIMEOUT_EN
      wd           <= '0;
`endif
    end else begin
      state        <= state_nx;
      frame_done_q <= good_commit;

      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_cap      <= cmd.cmd_op;
            val_cap     <= cmd.cmd_value;
            frames_cap  <= cmd.cmd_frames;
            remaining   <= cmd.cmd_frames;
            frames_done <= '0;
          end
        end
        S_LOAD: begin
          op_mode  <= op_cap;
          op_value <= val_cap;
        end
        S_START: begin
          col     <= '0;
          row     <= '0;
          pix_cnt <= '0;
`ifdef ENH_FRAME_TIMEOUT_EN
          wd      <= '0;
`endif
        end
        S_RUN: begin
          if (HSYNC) begin
            pix_cnt <= pix_inc;
            if (col == CW'(WIDTH/2 - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
`ifdef ENH_FRAME_TIMEOUT_EN
          wd <= HSYNC ? '0 : wd + WDW'(1);
`endif
          if (good_commit) begin
            frames_done <= frames_done + 8'd1;
            remaining   <= remaining - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign err           = (state == S_ERR);
  assign rd_start      = (state == S_START) && !abort;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_enh_frame_ctrl.sv
// Self-checking bench for enh_frame_ctrl with WIDTH=8, HEIGHT=4 (16 pairs per frame).
module tb_enh_frame_ctrl;

  logic       HCLK = 1'b0;
  logic       HRESET, abort, HSYNC, ctrl_done;
  logic       rd_start, busy, frame_done, err;
  logic [1:0] op_mode;
  logic [7:0] op_value, frames_done;
  logic [1:0] col, row;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;

  enh_frame_ctrl_if cmd_bus ();

  enh_frame_ctrl #(.WIDTH(8), .HEIGHT(4), .TIMEOUT_CYC(20)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cmd(cmd_bus), .abort(abort),
    .rd_start(rd_start), .HSYNC(HSYNC), .ctrl_done(ctrl_done),
    .op_mode(op_mode), .op_value(op_value), .col(col), .row(row),
    .busy(busy), .frame_done(frame_done), .frames_done(frames_done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (rd_start)   rd_cnt++;
    if (frame_done) fd_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_hsync(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      HSYNC = 1'b1;
      tick();
      HSYNC = 1'b0;
    end
  endtask

  // Issues a command and steps through LOAD and START; returns in the first RUN cycle.
  task automatic start_cmd(input logic [1:0] op, input logic [7:0] v, input logic [7:0] f);
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_op     = op;
    cmd_bus.cmd_value  = v;
    cmd_bus.cmd_frames = f;
    tick();
    cmd_bus.cmd_valid  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tick(); tick();
    HRESET = 1'b0;
    checks++; if (cmd_ready_s() !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready_s()); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL reset_err got %0b want 0", err); end
    checks++; if (rd_start !== 1'b0)    begin errors++; $display("FAIL reset_rd_start got %0b want 0", rd_start); end
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL reset_frames_done got %0d want 0", frames_done); end
    checks++; if (op_mode !== 2'd0)     begin errors++; $display("FAIL reset_op_mode got %0d want 0", op_mode); end
    checks++; if (op_value !== 8'd0)    begin errors++; $display("FAIL reset_op_value got %0d want 0", op_value); end
    checks++; if (col !== 2'd0 || row !== 2'd0) begin errors++; $display("FAIL reset_pos got col %0d row %0d want 0 0", col, row); end
  endtask

  function automatic logic cmd_ready_s();
    return cmd_bus.cmd_ready;
  endfunction

  task automatic test_basic();
    int rd0 = rd_cnt;
    int fd0 = fd_cnt;
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_op = 2'd0; cmd_bus.cmd_value = 8'd40; cmd_bus.cmd_frames = 8'd2;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || cmd_ready_s() !== 1'b0) begin errors++; $display("FAIL basic_load busy %0b ready %0b want 1 0", busy, cmd_ready_s()); end
    tick();
    checks++; if (rd_start !== 1'b1) begin errors++; $display("FAIL basic_first_start got %0b want 1", rd_start); end
    checks++; if (op_value !== 8'd40 || op_mode !== 2'd0) begin errors++; $display("FAIL basic_op_latch got %0d/%0d want 0/40", op_mode, op_value); end
    tick();
    checks++; if (rd_start !== 1'b0) begin errors++; $display("FAIL basic_start_width got %0b want 0", rd_start); end
    for (int f = 1; f <= 2; f++) begin
      pulse_hsync(16);
      checks++; if (op_value !== 8'd40) begin errors++; $display("FAIL basic_op_stable got %0d want 40", op_value); end
      ctrl_done = 1'b1;
      tick();
      ctrl_done = 1'b0;
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_frame_done%0d got %0b want 1", f, frame_done); end
      checks++; if (frames_done !== 8'(f)) begin errors++; $display("FAIL basic_frames_done got %0d want %0d", frames_done, f); end
      if (f == 1) begin
        checks++; if (rd_start !== 1'b1) begin errors++; $display("FAIL basic_restart got %0b want 1", rd_start); end
        tick();
      end else begin
        checks++; if (cmd_ready_s() !== 1'b1) begin errors++; $display("FAIL basic_idle got ready %0b want 1", cmd_ready_s()); end
      end
    end
    tick();
    checks++; if (rd_cnt - rd0 != 2 || fd_cnt - fd0 != 2) begin errors++; $display("FAIL basic_pulse_counts got rd %0d fd %0d want 2 2", rd_cnt - rd0, fd_cnt - fd0); end
  endtask

  task automatic test_short();
    int fd0 = fd_cnt;
    start_cmd(2'd1, 8'($urandom), 8'd1);
    pulse_hsync(15);
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    checks++; if (err !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL short_err got err %0b fd %0b want 1 0", err, frame_done); end
    HSYNC = 1'b1; ctrl_done = 1'b1;
    tick(); tick();
    HSYNC = 1'b0; ctrl_done = 1'b0;
    tick();
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL short_sticky got err %0b busy %0b want 1 1", err, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (cmd_ready_s() !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL short_abort got ready %0b err %0b want 1 0", cmd_ready_s(), err); end
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL short_no_frame_done got %0d want %0d", fd_cnt, fd0); end
  endtask

  task automatic test_overflow();
    start_cmd(2'd2, 8'($urandom), 8'd1);
    pulse_hsync(16);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", err); end
    HSYNC = 1'b1;
    tick();
    HSYNC = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %0b want 1", err); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_continuous();
    logic [1:0] op = 2'($urandom_range(0, 3));
    logic [7:0] v  = 8'($urandom);
    int rd0 = rd_cnt;
    int fd0 = fd_cnt;
    start_cmd(op, v, 8'd0);
    for (int f = 1; f <= 3; f++) begin
      pulse_hsync(16);
      if (f < 3) begin
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        checks++; if (frames_done !== 8'(f)) begin errors++; $display("FAIL cont_frames_done got %0d want %0d", frames_done, f); end
        tick();
      end else begin
        ctrl_done = 1'b1; abort = 1'b1;
        tick();
        ctrl_done = 1'b0; abort = 1'b0;
        checks++; if (cmd_ready_s() !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL cont_abort got ready %0b fd %0b want 1 0", cmd_ready_s(), frame_done); end
        checks++; if (frames_done !== 8'd2) begin errors++; $display("FAIL cont_abort_count got %0d want 2", frames_done); end
        checks++; if (op_mode !== op || op_value !== v) begin errors++; $display("FAIL cont_op_hold got %0d/%0d want %0d/%0d", op_mode, op_value, op, v); end
      end
    end
    tick();
    checks++; if (rd_cnt - rd0 != 3 || fd_cnt - fd0 != 2) begin errors++; $display("FAIL cont_pulses got rd %0d fd %0d want 3 2", rd_cnt - rd0, fd_cnt - fd0); end
  endtask

  task automatic test_position();
    start_cmd(2'd3, 8'($urandom), 8'd1);
    for (int k = 1; k <= 16; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      HSYNC = 1'b1;
      if (k == 16) ctrl_done = 1'b1;
      tick();
      HSYNC = 1'b0; ctrl_done = 1'b0;
      if (k < 16) begin
        checks++; if (col !== 2'(k % 4) || row !== 2'(k / 4)) begin errors++; $display("FAIL pos_k%0d got col %0d row %0d want %0d %0d", k, col, row, k % 4, k / 4); end
      end else begin
        checks++; if (frame_done !== 1'b1 || frames_done !== 8'd1) begin errors++; $display("FAIL pos_same_cycle got fd %0b cnt %0d want 1 1", frame_done, frames_done); end
        checks++; if (cmd_ready_s() !== 1'b1) begin errors++; $display("FAIL pos_idle got %0b want 1", cmd_ready_s()); end
      end
    end
    tick();
  endtask

  task automatic test_idle_ignore();
    int fd0 = fd_cnt;
    HSYNC = 1'b1; ctrl_done = 1'b1;
    repeat (3) tick();
    HSYNC = 1'b0; ctrl_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || frames_done !== 8'd1 || col !== 2'd0) begin errors++; $display("FAIL idle_ignore got busy %0b cnt %0d col %0d want 0 1 0", busy, frames_done, col); end
    checks++; if (fd_cnt != fd0 || err !== 1'b0) begin errors++; $display("FAIL idle_no_pulse got fd %0d err %0b want %0d 0", fd_cnt, err, fd0); end
  endtask

  task automatic test_timeout();
    start_cmd(2'd0, 8'($urandom), 8'd1);
`ifdef ENH_FRAME_TIMEOUT_EN
    repeat (19) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_early got %0b want 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_fire got %0b want 1", err); end
`else
    repeat (100) tick();
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_wd got err %0b busy %0b want 0 1", err, busy); end
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int rd0, fd0;
    start_cmd(2'd1, 8'd200, 8'd2);
    pulse_hsync(5);
    rd0 = rd_cnt; fd0 = fd_cnt;
    HRESET = 1'b1; HSYNC = 1'b1; ctrl_done = 1'b1;
    tick();
    HRESET = 1'b0; HSYNC = 1'b0; ctrl_done = 1'b0;
    checks++; if (busy !== 1'b0 || cmd_ready_s() !== 1'b1) begin errors++; $display("FAIL mid_reset_state got busy %0b ready %0b want 0 1", busy, cmd_ready_s()); end
    checks++; if (col !== 2'd0 || row !== 2'd0 || op_value !== 8'd0 || frames_done !== 8'd0) begin errors++; $display("FAIL mid_reset_regs got col %0d row %0d val %0d cnt %0d want 0 0 0 0", col, row, op_value, frames_done); end
    tick();
    checks++; if (rd_cnt != rd0 || fd_cnt != fd0) begin errors++; $display("FAIL mid_reset_pulses got rd %0d fd %0d want %0d %0d", rd_cnt, fd_cnt, rd0, fd0); end
  endtask

  initial begin
    HRESET = 1'b1; abort = 1'b0; HSYNC = 1'b0; ctrl_done = 1'b0;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_op = '0; cmd_bus.cmd_value = '0; cmd_bus.cmd_frames = '0;
    test_reset();
    test_basic();
    test_short();
    test_overflow();
    test_continuous();
    test_position();
    test_idle_ignore();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
